// File: rtl/m68k_bus_responder.sv
// Responder side of the 68000 bus cycle: turns region chip selects into DTACK_n,
// fetching ROM words over the SDRAM handshake. Optional ROM timeout: M68K_ROM_TIMEOUT_EN.
module m68k_bus_responder #(
    parameter int FAST_WAIT   = 1,
    parameter int ROM_TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        m68k_as_n,
    input  logic        m68k_rw,
    input  logic [23:0] m68k_a,
    input  logic        rom_cs,
    input  logic        fast_cs,
    input  logic [15:0] fast_dout,
    output logic        rom_req,
    output logic [22:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        rom_valid,
    output logic [15:0] m68k_din,
    output logic        m68k_dtack_n,
    output logic        busy
);

    // state   | meaning
    // IDLE    | waiting for a registered AS_n low
    // WAIT    | fixed-latency region (fast, unmapped or ROM write) counting down to DTACK
    // ROM_REQ | SDRAM read outstanding, waiting for rom_valid
    // ACK     | DTACK_n low until the CPU releases AS_n
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_ROM_REQ = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    localparam int             WCW       = (FAST_WAIT > 1) ? $clog2(FAST_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(FAST_WAIT - 1);

    logic [1:0]     state;
    logic           as_q;
    logic [WCW-1:0] wait_cnt;
    logic           fast_sel;

    // Byte lane A0 is never part of a word fetch.
    logic unused_a0;
    assign unused_a0 = m68k_a[0];

`ifdef M68K_ROM_TIMEOUT_EN
    localparam int             TCW      = (ROM_TIMEOUT > 1) ? $clog2(ROM_TIMEOUT) : 1;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(ROM_TIMEOUT - 1);
    logic [TCW-1:0] tmo_cnt;
`else
    localparam int unused_rom_timeout = ROM_TIMEOUT;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= S_IDLE;
            as_q         <= 1'b1;
            wait_cnt     <= '0;
            fast_sel     <= 1'b0;
            rom_req      <= 1'b0;
            rom_addr     <= '0;
            m68k_din     <= 16'hFFFF;
            m68k_dtack_n <= 1'b1;
`ifdef M68K_ROM_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            as_q <= m68k_as_n;
            case (state)
                S_IDLE: begin
                    if (!as_q) begin
                        wait_cnt <= '0;
                        // ROM writes fall through to WAIT with fast_sel low, so they read back FFFF
                        fast_sel <= fast_cs & ~rom_cs;
                        if (rom_cs && m68k_rw) begin
                            rom_addr <= m68k_a[23:1];
                            rom_req  <= 1'b1;
                            state    <= S_ROM_REQ;
`ifdef M68K_ROM_TIMEOUT_EN
                            tmo_cnt  <= '0;
`endif
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (as_q) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        m68k_din     <= fast_sel ? fast_dout : 16'hFFFF;
                        m68k_dtack_n <= 1'b0;
                        state        <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ROM_REQ: begin
                    if (as_q) begin
                        // Aborted cycle: drop the request; any late rom_valid lands in IDLE and is ignored
                        rom_req <= 1'b0;
                        state   <= S_IDLE;
                    end else if (rom_valid) begin
                        m68k_din     <= rom_data;
                        rom_req      <= 1'b0;
                        m68k_dtack_n <= 1'b0;
                        state        <= S_ACK;
                    end
`ifdef M68K_ROM_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        m68k_din     <= 16'hFFFF;
                        rom_req      <= 1'b0;
                        m68k_dtack_n <= 1'b0;
                        state        <= S_ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    if (as_q) begin
                        m68k_dtack_n <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
